// File: rtl/fp_normalizer.sv
// Normalization stage for the 1-4-8 floating-point adder result.
// Accepts a raw sum and shifts it one bit position per clock until it is
// normalized. Then it presents sign/exponent/fraction with overflow and
// underflow flags over a valid/ready handshake.
module fp_normalizer (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [3:0] in_exp,
  input  logic [8:0] in_sum,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sign_out,
  output logic [3:0] exp_out,
  output logic [7:0] frac_out,
  output logic       ovf,
  output logic       udf
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t     state, state_nx;
  logic       s, s_nx;
  logic [3:0] e, e_nx;
  logic [8:0] m, m_nx;
  logic       of, of_nx;
  logic       uf, uf_nx;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // Next-state and working-register update, one normalization step per cycle
  always_comb begin
    state_nx = state;
    s_nx     = s;
    e_nx     = e;
    m_nx     = m;
    of_nx    = of;
    uf_nx    = uf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          s_nx     = in_sign;
          e_nx     = in_exp;
          m_nx     = in_sum;
          of_nx    = 1'b0;
          uf_nx    = 1'b0;
          state_nx = NORM;
        end
      end
      NORM: begin
        state_nx = DONE;
        if (m == '0) begin
          s_nx = 1'b0;
          e_nx = '0;
        end else if (m[8] && (e == 4'd15)) begin
          e_nx  = 4'd15;
          m_nx  = 9'h0FF;
          of_nx = 1'b1;
        end else if (m[8]) begin
          m_nx = m >> 1;
          e_nx = e + 4'd1;
        end else if (m[7]) begin
          state_nx = DONE;
        end else if (e == '0) begin
          s_nx  = 1'b0;
          m_nx  = '0;
          uf_nx = 1'b1;
        end else begin
          m_nx     = m << 1;
          e_nx     = e - 4'd1;
          state_nx = NORM;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and working registers; output registers load only when a result
  // is finalized so they keep the last delivered value while idle/shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s        <= 1'b0;
      e        <= '0;
      m        <= '0;
      of       <= 1'b0;
      uf       <= 1'b0;
      sign_out <= 1'b0;
      exp_out  <= '0;
      frac_out <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      e     <= e_nx;
      m     <= m_nx;
      of    <= of_nx;
      uf    <= uf_nx;
      if ((state == NORM) && (state_nx == DONE)) begin
        sign_out <= s_nx;
        exp_out  <= e_nx;
        frac_out <= m_nx[7:0];
        ovf      <= of_nx;
        udf      <= uf_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: directed vectors with literal expectations plus a
// value-level reference model, checked by a single negedge monitor.
module tb_fp_normalizer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [3:0] in_exp;
  logic [8:0] in_sum;
  logic       out_valid;
  logic       out_ready;
  logic       sign_out;
  logic [3:0] exp_out;
  logic [7:0] frac_out;
  logic       ovf;
  logic       udf;

  fp_normalizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .sign_out(sign_out),
    .exp_out(exp_out), .frac_out(frac_out), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [3:0] e;
    logic [7:0] f;
    logic       o;
    logic       u;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   ncmp  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  bit   seen  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: locate the leading one, then decide carry / shift / flush
  function automatic exp_t model(input logic sg, input logic [3:0] ex, input logic [8:0] sm);
    exp_t r;
    int p, k;
    logic [8:0] t;
    r.s = sg; r.e = ex; r.f = '0; r.o = 1'b0; r.u = 1'b0; r.lat = 1; r.acc = 0;
    if (sm == 9'd0) begin
      r.s = 1'b0; r.e = '0;
    end else if (sm >= 9'd256) begin
      if (ex == 4'd15) begin
        r.e = 4'd15; r.f = 8'hFF; r.o = 1'b1;
      end else begin
        r.e = ex + 4'd1; r.f = sm[8:1];
      end
    end else begin
      p = 0;
      for (int i = 0; i < 8; i++) if (sm[i]) p = i;
      k = 7 - p;
      if (k <= int'(ex)) begin
        t = sm << k;
        r.e = 4'(int'(ex) - k); r.f = t[7:0]; r.lat = k + 1;
      end else begin
        r.s = 1'b0; r.e = '0; r.u = 1'b1; r.lat = int'(ex) + 1;
      end
    end
    return r;
  endfunction

  // Single compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc - q[0].acc, q[0].lat);
        end
        chk("sign_out", sign_out, q[0].s);
        chk("exp_out", exp_out, q[0].e);
        chk("frac_out", frac_out, q[0].f);
        chk("ovf", ovf, q[0].o);
        chk("udf", udf, q[0].u);
        chk("in_ready_in_done", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Present one operand (caller is just after a posedge); returns the number
  // of cycles spent waiting for in_ready.
  task automatic send_e(input logic sg, input logic [3:0] ex, input logic [8:0] sm,
                        input exp_t x, output int waits);
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_sum = sm;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    x.acc = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic sg, input logic [3:0] ex, input logic [8:0] sm);
    int w;
    send_e(sg, ex, sm, model(sg, ex, sm), w);
  endtask

  task automatic send_l(input logic sg, input logic [3:0] ex, input logic [8:0] sm,
                        input logic rs, input logic [3:0] re, input logic [7:0] rf,
                        input logic ro, input logic ru, input int lat);
    exp_t x;
    int w;
    x.s = rs; x.e = re; x.f = rf; x.o = ro; x.u = ru; x.lat = lat; x.acc = 0;
    send_e(sg, ex, sm, x, w);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sign_out"}, sign_out, 0);
    chk({tag, "_exp_out"}, exp_out, 0);
    chk({tag, "_frac_out"}, frac_out, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_udf"}, udf, 0);
  endtask

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sum = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk_zero_outs("rst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Literal test-plan vectors
    send_l(1'b1, 4'd5,  9'h0C0, 1'b1, 4'd5,  8'hC0, 1'b0, 1'b0, 1);
    send_l(1'b0, 4'd6,  9'h181, 1'b0, 4'd7,  8'hC0, 1'b0, 1'b0, 1);
    send_l(1'b0, 4'd15, 9'h100, 1'b0, 4'd15, 8'hFF, 1'b1, 1'b0, 1);
    send_l(1'b0, 4'd9,  9'h001, 1'b0, 4'd2,  8'h80, 1'b0, 1'b0, 8);
    send_l(1'b1, 4'd3,  9'h000, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1);
    send_l(1'b0, 4'd2,  9'h010, 1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 3);

    // Model-checked boundary vectors
    send_m(1'b0, 4'd3,  9'h0FF);
    send_m(1'b1, 4'd14, 9'h1FE);
    send_m(1'b1, 4'd15, 9'h1FF);
    send_m(1'b0, 4'd1,  9'h001);
    send_m(1'b1, 4'd7,  9'h001);
    send_m(1'b0, 4'd4,  9'h03C);
    send_m(1'b1, 4'd0,  9'h040);
    send_m(1'b1, 4'd0,  9'h080);
    send_m(1'b0, 4'd6,  9'h00A);
    drain();

    // Backpressure: hold DONE for 5 cycles, then a back-to-back accept
    out_ready = 1'b0;
    send_m(1'b1, 4'd5, 9'h0C0);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("bp_reached_done", out_valid, 1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    send_e(1'b0, 4'd8, 9'h020, model(1'b0, 4'd8, 9'h020), w);
    chk("bp_in_ready_next_cycle_waits", w, 1);
    drain();

    // Reset in the middle of a shift sequence discards the operand
    send_m(1'b1, 4'd9, 9'h004);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    seen = 0;
    @(negedge clk);
    chk("midrst_in_ready_low", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero_outs("midrst");
    chk("midrst_in_ready_high", in_ready, 1);
    repeat (12) @(negedge clk);
    chk("midrst_no_valid", out_valid, 0);

    // Normal operation resumes after reset
    @(posedge clk); #1;
    send_m(1'b0, 4'd10, 9'h004);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
